// File: rtl/ghost_move_scheduler_pkg.sv
// Shared constants, state encoding and helpers for the ghost move scheduler.
package ghost_move_scheduler_pkg;

  localparam logic [2:0] PACMAN = 3'd0;
  localparam logic [2:0] GHOST1 = 3'd1;
  localparam logic [2:0] GHOST2 = 3'd2;
  localparam logic [2:0] GHOST3 = 3'd3;
  localparam logic [2:0] GHOST4 = 3'd4;

  localparam int DEFAULT_X_MAX = 159;
  localparam int DEFAULT_Y_MAX = 119;

  typedef enum logic [3:0] {
    IDLE,
    PAC_RD,
    PAC_CAP,
    G_RD,
    G_CAP,
    Q_PRI,
    Q_ALT,
    WRITE,
    NEXT,
    DONE
  } state_e;

  // Lowest enabled ghost strictly above cur; PACMAN (0) when none remain.
  function automatic logic [2:0] next_ghost(input logic [3:0] mask, input logic [2:0] cur);
    logic [2:0] nxt;
    nxt = PACMAN;
    if (cur < GHOST1 && mask[0]) nxt = GHOST1;
    else if (cur < GHOST2 && mask[1]) nxt = GHOST2;
    else if (cur < GHOST3 && mask[2]) nxt = GHOST3;
    else if (cur < GHOST4 && mask[3]) nxt = GHOST4;
    return nxt;
  endfunction

endpackage

// File: rtl/ghost_move_scheduler_step_calc.sv
// Combinational chase-step proposal: primary/alternate one-step candidates toward Pacman.
module ghost_step_calc
  import ghost_move_scheduler_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int X_MAX = DEFAULT_X_MAX,
  parameter int Y_MAX = DEFAULT_Y_MAX
) (
  input  logic [7:0] pac_x,
  input  logic [7:0] pac_y,
  input  logic [7:0] ghost_x,
  input  logic [7:0] ghost_y,
  output logic [7:0] pri_x,
  output logic [7:0] pri_y,
  output logic       pri_valid,
  output logic [7:0] alt_x,
  output logic [7:0] alt_y,
  output logic       alt_valid
);

  logic signed [8:0] dx, dy;
  logic [8:0] abs_dx, abs_dy;
  logic [7:0] cand_x, cand_y;
  logic x_ok, y_ok, x_primary;

  // Move cur by STEP in the direction of d, saturating at 0 and at lim.
  // Extra headroom bits keep cur+STEP from wrapping before the clamp.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic signed [8:0] d,
                                             input int lim);
    logic [9:0] wide;
    wide = {2'b00, cur};
    if (d != 9'sd0) begin
      if (!d[8]) wide = {2'b00, cur} + 10'(STEP);
      else if ({2'b00, cur} < 10'(STEP)) wide = 10'd0;
      else wide = {2'b00, cur} - 10'(STEP);
    end
    if (wide > 10'(lim)) wide = 10'(lim);
    return wide[7:0];
  endfunction

  // Signed distances, per-axis candidates, and primary/alternate ordering (ties favour x).
  always_comb begin
    dx = $signed({1'b0, pac_x}) - $signed({1'b0, ghost_x});
    dy = $signed({1'b0, pac_y}) - $signed({1'b0, ghost_y});
    abs_dx = dx[8] ? 9'(-dx) : 9'(dx);
    abs_dy = dy[8] ? 9'(-dy) : 9'(dy);
    cand_x = step_toward(ghost_x, dx, X_MAX);
    cand_y = step_toward(ghost_y, dy, Y_MAX);
    x_ok = (dx != 9'sd0) && (cand_x != ghost_x);
    y_ok = (dy != 9'sd0) && (cand_y != ghost_y);
    x_primary = (abs_dx >= abs_dy);
    if (x_primary) begin
      pri_x = cand_x;  pri_y = ghost_y; pri_valid = x_ok;
      alt_x = ghost_x; alt_y = cand_y;  alt_valid = y_ok;
    end else begin
      pri_x = ghost_x; pri_y = cand_y;  pri_valid = y_ok;
      alt_x = cand_x;  alt_y = ghost_y; alt_valid = x_ok;
    end
  end

endmodule

// File: rtl/ghost_move_scheduler.sv
// Per-tick round sequencer: reads Pacman and each enabled ghost, queries the maze, writes moves back.
module ghost_move_scheduler
  import ghost_move_scheduler_pkg::*;
#(
  parameter int STEP  = 1,
  parameter int X_MAX = DEFAULT_X_MAX,
  parameter int Y_MAX = DEFAULT_Y_MAX
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] ghost_enable,
  input  logic [7:0] regs_x_out,
  input  logic [7:0] regs_y_out,
  output logic [2:0] character_type,
  output logic       readwrite,
  output logic [7:0] x_in,
  output logic [7:0] y_in,
  output logic       query_req,
  output logic [7:0] query_x,
  output logic [7:0] query_y,
  input  logic       query_done,
  input  logic       query_blocked,
  output logic       busy,
  output logic       done,
  output logic       tick_overrun
);

  state_e state_q, state_d;
  logic pend_q, pend_d;
  logic [3:0] mask_q, mask_d;
  logic [2:0] g_q, g_d, nxt_ghost;
  logic [7:0] pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic [7:0] gx_q, gx_d, gy_q, gy_d;
  logic [7:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [7:0] calc_gx, calc_gy, pri_x, pri_y, alt_x, alt_y;
  logic pri_valid, alt_valid;

  // In G_CAP the ghost coordinate is still on the read bus, so decide from it directly.
  assign calc_gx = (state_q == G_CAP) ? regs_x_out : gx_q;
  assign calc_gy = (state_q == G_CAP) ? regs_y_out : gy_q;
  assign nxt_ghost = next_ghost(mask_q, g_q);

  ghost_step_calc #(.STEP(STEP), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_calc (
    .pac_x(pac_x_q), .pac_y(pac_y_q), .ghost_x(calc_gx), .ghost_y(calc_gy),
    .pri_x(pri_x), .pri_y(pri_y), .pri_valid(pri_valid),
    .alt_x(alt_x), .alt_y(alt_y), .alt_valid(alt_valid)
  );

  // Next-state, pending-tick and datapath-capture logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mask_d  = mask_q;
    g_d     = g_q;
    pac_x_d = pac_x_q;
    pac_y_d = pac_y_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (state_q != IDLE && tick && !pend_q) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = PAC_RD;
          mask_d  = ghost_enable;
          g_d     = PACMAN;
          pend_d  = tick && pend_q;
        end
      end
      PAC_RD: state_d = PAC_CAP;
      PAC_CAP: begin
        pac_x_d = regs_x_out;
        pac_y_d = regs_y_out;
        if (nxt_ghost != PACMAN) begin
          g_d = nxt_ghost;
          state_d = G_RD;
        end else begin
          state_d = DONE;
        end
      end
      G_RD: state_d = G_CAP;
      G_CAP: begin
        gx_d = regs_x_out;
        gy_d = regs_y_out;
        if (pri_valid) state_d = Q_PRI;
        else if (alt_valid) state_d = Q_ALT;
        else state_d = NEXT;
      end
      Q_PRI: begin
        if (query_done) begin
          if (!query_blocked) begin
            acc_x_d = pri_x;
            acc_y_d = pri_y;
            state_d = WRITE;
          end else if (alt_valid) begin
            state_d = Q_ALT;
          end else begin
            state_d = NEXT;
          end
        end
      end
      Q_ALT: begin
        if (query_done) begin
          if (!query_blocked) begin
            acc_x_d = alt_x;
            acc_y_d = alt_y;
            state_d = WRITE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      WRITE, NEXT: begin
        if (nxt_ghost != PACMAN) begin
          g_d = nxt_ghost;
          state_d = G_RD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      mask_q  <= 4'd0;
      g_q     <= PACMAN;
      pac_x_q <= 8'd0;
      pac_y_q <= 8'd0;
      gx_q    <= 8'd0;
      gy_q    <= 8'd0;
      acc_x_q <= 8'd0;
      acc_y_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      g_q     <= g_d;
      pac_x_q <= pac_x_d;
      pac_y_q <= pac_y_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
    end
  end

  // Register-file and maze-query port decode; writes only ever happen in WRITE.
  always_comb begin
    character_type = PACMAN;
    readwrite      = 1'b0;
    x_in           = 8'd0;
    y_in           = 8'd0;
    query_req      = 1'b0;
    query_x        = 8'd0;
    query_y        = 8'd0;
    case (state_q)
      G_RD, G_CAP, NEXT: character_type = g_q;
      Q_PRI: begin
        character_type = g_q;
        query_req = 1'b1;
        query_x = pri_x;
        query_y = pri_y;
      end
      Q_ALT: begin
        character_type = g_q;
        query_req = 1'b1;
        query_x = alt_x;
        query_y = alt_y;
      end
      WRITE: begin
        character_type = g_q;
        readwrite = 1'b1;
        x_in = acc_x_q;
        y_in = acc_y_q;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign tick_overrun = tick && pend_q && (state_q != IDLE);

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Scoreboard bench: a chase-rule model predicts queries/writes, monitors pop and compare.
module tb_ghost_move_scheduler;

  localparam int STEP = 1;
  localparam int XM = 159;
  localparam int YM = 119;

  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic [3:0] ghost_enable = 4'd0;
  logic [7:0] regs_x_out, regs_y_out;
  logic [2:0] character_type;
  logic readwrite;
  logic [7:0] x_in, y_in;
  logic query_req;
  logic [7:0] query_x, query_y;
  logic query_done = 1'b0;
  logic query_blocked = 1'b0;
  logic busy, done, tick_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int last_done_cyc = 0;
  int tick_cyc = 0;

  typedef struct {int t; int x; int y;} wr_t;
  typedef struct {int x; int y;} pt_t;
  wr_t exp_wr[$];
  pt_t exp_q[$];

  int mp_x[5], mp_y[5];
  bit wall[160][120];
  int max_delay = 0;
  bit q_hang = 0;
  bit spur_en = 0;

  always #5 clock_50 = ~clock_50;

  ghost_move_scheduler #(.STEP(STEP), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clock_50(clock_50), .reset(reset), .tick(tick), .ghost_enable(ghost_enable),
    .regs_x_out(regs_x_out), .regs_y_out(regs_y_out),
    .character_type(character_type), .readwrite(readwrite), .x_in(x_in), .y_in(y_in),
    .query_req(query_req), .query_x(query_x), .query_y(query_y),
    .query_done(query_done), .query_blocked(query_blocked),
    .busy(busy), .done(done), .tick_overrun(tick_overrun)
  );

  logic [7:0] c4_px = 8'd0, c4_py = 8'd0, c4_gx = 8'd0, c4_gy = 8'd0;
  logic [7:0] c4_pri_x, c4_pri_y, c4_alt_x, c4_alt_y;
  logic c4_pri_v, c4_alt_v;

  ghost_step_calc #(.STEP(4), .X_MAX(XM), .Y_MAX(YM)) u_calc4 (
    .pac_x(c4_px), .pac_y(c4_py), .ghost_x(c4_gx), .ghost_y(c4_gy),
    .pri_x(c4_pri_x), .pri_y(c4_pri_y), .pri_valid(c4_pri_v),
    .alt_x(c4_alt_x), .alt_y(c4_alt_y), .alt_valid(c4_alt_v)
  );

  // Register file: one-cycle registered read, write when readwrite is high, backdoor load.
  logic [7:0] mem_x[8], mem_y[8];
  logic [7:0] bd_x[8], bd_y[8];
  logic bd_load = 1'b0;
  always @(posedge clock_50) begin
    if (bd_load) begin
      for (int i = 0; i < 8; i++) begin
        mem_x[i] <= bd_x[i];
        mem_y[i] <= bd_y[i];
      end
    end else if (readwrite) begin
      mem_x[character_type] <= x_in;
      mem_y[character_type] <= y_in;
    end
    regs_x_out <= mem_x[character_type];
    regs_y_out <= mem_y[character_type];
  end

  always @(posedge clock_50) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    if (v < 0) return 0;
    if (v > lim) return lim;
    return v;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: each enabled ghost tries the larger-gap axis, then the other, stepping toward Pacman.
  task automatic model_round(input logic [3:0] mask);
    for (int g = 1; g <= 4; g++) begin
      int dx, dy, d, cx, cy;
      bit x_first, use_x;
      if (!mask[g-1]) continue;
      dx = mp_x[0] - mp_x[g];
      dy = mp_y[0] - mp_y[g];
      x_first = absi(dx) >= absi(dy);
      for (int k = 0; k < 2; k++) begin
        use_x = (k == 0) ? x_first : !x_first;
        d = use_x ? dx : dy;
        if (d == 0) continue;
        cx = mp_x[g];
        cy = mp_y[g];
        if (use_x) cx = clampi(cx + ((d > 0) ? STEP : -STEP), XM);
        else cy = clampi(cy + ((d > 0) ? STEP : -STEP), YM);
        if (cx == mp_x[g] && cy == mp_y[g]) continue;
        exp_q.push_back('{cx, cy});
        if (!wall[cx][cy]) begin
          exp_wr.push_back('{g, cx, cy});
          mp_x[g] = cx;
          mp_y[g] = cy;
          break;
        end
      end
    end
  endtask

  // Maze responder with random latency; checks each answered query against the scoreboard.
  bit q_active = 0;
  int q_wait = 0, q_target = 0;
  int q_hx = 0, q_hy = 0;
  pt_t q_e;
  always @(negedge clock_50) begin
    if (query_done) query_done = 1'b0;
    if (query_req) begin
      if (!q_active) begin
        q_active = 1;
        q_hx = query_x;
        q_hy = query_y;
        q_wait = 0;
        q_target = q_hang ? 1000000 : $urandom_range(0, max_delay);
      end else begin
        checkOutput("query_x_stable", query_x, q_hx);
        checkOutput("query_y_stable", query_y, q_hy);
      end
      if (q_wait >= q_target) begin
        if (exp_q.size() == 0) checkOutput("unexpected_query", 1, 0);
        else begin
          q_e = exp_q.pop_front();
          checkOutput("query_x", q_hx, q_e.x);
          checkOutput("query_y", q_hy, q_e.y);
        end
        query_blocked = (q_hx < 160 && q_hy < 120) ? wall[q_hx][q_hy] : 1'b0;
        query_done = 1'b1;
        q_active = 0;
      end else begin
        q_wait++;
      end
    end else begin
      q_active = 0;
      if (spur_en && $urandom_range(0, 7) == 0) begin
        query_done = 1'b1;
        query_blocked = 1'($urandom_range(0, 1));
      end
    end
  end

  // Write monitor: every write must be expected and last exactly one cycle.
  bit prev_rw = 0;
  wr_t w_e;
  always @(negedge clock_50) begin
    if (readwrite) begin
      checkOutput("rw_single_cycle", int'(prev_rw), 0);
      if (exp_wr.size() == 0) checkOutput("unexpected_write", 1, 0);
      else begin
        w_e = exp_wr.pop_front();
        checkOutput("write_type", character_type, w_e.t);
        checkOutput("write_x", x_in, w_e.x);
        checkOutput("write_y", y_in, w_e.y);
      end
    end
    prev_rw = readwrite;
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (tick_overrun) ovr_cnt++;
  end

  task automatic setChar(input int idx, input int x, input int y);
    bd_x[idx] = 8'(x);
    bd_y[idx] = 8'(y);
    mp_x[idx] = x;
    mp_y[idx] = y;
  endtask

  task automatic loadChars();
    @(negedge clock_50) bd_load = 1'b1;
    @(negedge clock_50) bd_load = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input bit predict);
    if (predict) model_round(mask);
    ghost_enable = mask;
    @(negedge clock_50);
    tick = 1'b1;
    tick_cyc = cyc;
    @(negedge clock_50);
    tick = 1'b0;
  endtask

  task automatic waitRounds(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(negedge clock_50);
      n++;
    end
    if (done_cnt < target) checkOutput("round_timeout", done_cnt, target);
    repeat (3) @(negedge clock_50);
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_writes_left"}, exp_wr.size(), 0);
    checkOutput({tag, "_queries_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base, obase, n;
    for (int i = 0; i < 8; i++) begin
      bd_x[i] = 8'd0;
      bd_y[i] = 8'd0;
    end
    for (int i = 0; i < 5; i++) begin
      mp_x[i] = 0;
      mp_y[i] = 0;
    end
    repeat (3) @(negedge clock_50);
    checkOutput("rst_character_type", character_type, 0);
    checkOutput("rst_readwrite", readwrite, 0);
    checkOutput("rst_x_in", x_in, 0);
    checkOutput("rst_y_in", y_in, 0);
    checkOutput("rst_query_req", query_req, 0);
    checkOutput("rst_query_x", query_x, 0);
    checkOutput("rst_query_y", query_y, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_tick_overrun", tick_overrun, 0);
    reset = 1'b0;

    $display("[TB] single ghost, zero-wait responder");
    setChar(0, 40, 35); setChar(1, 45, 35); setChar(2, 10, 10);
    setChar(3, 20, 20); setChar(4, 30, 30);
    loadChars();
    base = done_cnt;
    applyStimulus(4'b0001, 1);
    waitRounds(base + 1);
    checkOutput("done_latency_1g", last_done_cyc - tick_cyc, 7);
    checkOutput("regfile_g1_x", mem_x[1], 44);
    checkDrained("one_ghost");

    $display("[TB] four ghosts, zero-wait responder");
    setChar(0, 80, 60); setChar(1, 70, 60); setChar(2, 90, 60);
    setChar(3, 80, 50); setChar(4, 85, 70);
    loadChars();
    base = done_cnt;
    applyStimulus(4'b1111, 1);
    waitRounds(base + 1);
    checkOutput("done_latency_4g", last_done_cyc - tick_cyc, 19);
    checkDrained("four_ghosts");

    $display("[TB] primary blocked, alternate accepted");
    setChar(0, 40, 35); setChar(2, 45, 30);
    loadChars();
    wall[44][30] = 1;
    base = done_cnt;
    applyStimulus(4'b0010, 1);
    waitRounds(base + 1);
    wall[44][30] = 0;
    checkOutput("blocked_g2_y", mem_y[2], 31);
    checkDrained("blocked");

    $display("[TB] ghost on Pacman");
    setChar(3, 40, 35);
    loadChars();
    base = done_cnt;
    applyStimulus(4'b0100, 1);
    waitRounds(base + 1);
    checkOutput("same_pos_rounds", done_cnt - base, 1);
    checkDrained("same_pos");

    c4_gx = 8'd2; c4_gy = 8'd50; c4_px = 8'd0; c4_py = 8'd50;
    #1;
    checkOutput("clamp_low_x", c4_pri_x, 0);
    checkOutput("clamp_low_valid", c4_pri_v, 1);
    checkOutput("clamp_low_alt_valid", c4_alt_v, 0);
    c4_gx = 8'd157; c4_gy = 8'd60; c4_px = 8'd159; c4_py = 8'd60;
    #1;
    checkOutput("clamp_high_x", c4_pri_x, 159);
    c4_gx = 8'd80; c4_gy = 8'd117; c4_px = 8'd80; c4_py = 8'd119;
    #1;
    checkOutput("clamp_high_y", c4_pri_y, 119);
    checkOutput("clamp_high_y_alt_x", c4_alt_x, 80);

    $display("[TB] ticks while busy");
    setChar(0, 80, 60); setChar(1, 60, 60); setChar(2, 100, 60);
    setChar(3, 80, 40); setChar(4, 95, 80);
    loadChars();
    base = done_cnt;
    obase = ovr_cnt;
    applyStimulus(4'b1111, 1);
    repeat (2) @(negedge clock_50);
    applyStimulus(4'b1111, 1);
    repeat (2) @(negedge clock_50);
    applyStimulus(4'b1111, 0);
    waitRounds(base + 2);
    repeat (40) @(negedge clock_50);
    checkOutput("done_pulses_two", done_cnt - base, 2);
    checkOutput("overrun_pulses", ovr_cnt - obase, 1);
    checkDrained("pending");

    $display("[TB] reset while querying");
    setChar(0, 40, 50); setChar(1, 50, 50);
    loadChars();
    q_hang = 1;
    base = done_cnt;
    applyStimulus(4'b0001, 1);
    n = 0;
    while (!query_req && n < 50) begin
      @(negedge clock_50);
      n++;
    end
    checkOutput("reached_q_pri", query_req, 1);
    reset = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    checkOutput("rst_mid_query_req", query_req, 0);
    checkOutput("rst_mid_readwrite", readwrite, 0);
    checkOutput("rst_mid_busy", busy, 0);
    exp_q.delete();
    exp_wr.delete();
    model_round(4'b0000);
    mp_x[1] = 50;
    q_hang = 0;
    max_delay = 3;
    repeat (3) @(negedge clock_50);
    checkOutput("rst_no_write", mem_x[1], 50);
    checkOutput("rst_no_done", done_cnt - base, 0);
    applyStimulus(4'b0001, 1);
    waitRounds(base + 1);
    checkOutput("post_rst_g1_x", mem_x[1], 49);
    checkDrained("post_reset");

    $display("[TB] randomized rounds, delayed responder");
    spur_en = 1;
    for (int r = 0; r < 24; r++) begin
      logic [3:0] mask;
      int px, py;
      if (r % 6 == 0) begin
        for (int x = 0; x < 160; x++)
          for (int y = 0; y < 120; y++)
            wall[x][y] = ($urandom_range(0, 3) == 0);
      end
      if (r % 3 == 0) begin
        px = $urandom_range(0, XM);
        py = $urandom_range(0, YM);
        setChar(0, px, py);
        for (int g = 1; g <= 4; g++) begin
          case ($urandom_range(0, 3))
            0: setChar(g, px, py);
            1: setChar(g, clampi(px + int'($urandom_range(0, 6)) - 3, XM),
                          clampi(py + int'($urandom_range(0, 6)) - 3, YM));
            2: setChar(g, ($urandom_range(0, 1) == 1) ? XM : 0, $urandom_range(0, YM));
            default: setChar(g, $urandom_range(0, XM), $urandom_range(0, YM));
          endcase
        end
        loadChars();
      end
      mask = 4'($urandom_range(0, 15));
      base = done_cnt;
      applyStimulus(mask, 1);
      waitRounds(base + 1);
      checkDrained("random");
    end
    spur_en = 0;
    for (int g = 1; g <= 4; g++) begin
      checkOutput("final_pos_x", mem_x[g], mp_x[g]);
      checkOutput("final_pos_y", mem_y[g], mp_y[g]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost_move_scheduler.md
# ghost_move_scheduler

Sequences the single-port character coordinate register file so that all four ghosts take one chase step toward Pacman per game tick. On each tick it reads Pacman's position, then for each enabled ghost it:
- reads the ghost's position,
- proposes a one-step move,
- checks the move against the maze through a query handshake,
- writes the accepted position back.

It is the only master of the register file's `character_type`/`readwrite`/`x_in`/`y_in` port.

## Interface
Parameters:
- `STEP`, 1: pixels moved per ghost per tick.
- `X_MAX`, 159: largest legal x pixel coordinate.
- `Y_MAX`, 119: largest legal y pixel coordinate.

Ports:
- `clock_50` input 1: the only clock. All logic is on its rising edge.
- `reset` input 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `tick` input 1: one-cycle game-tick pulse that requests a movement round.
- `ghost_enable` input 4: bit i-1 enables ghost i. It is sampled at round start.
- `regs_x_out`, `regs_y_out` input 8 each: read data from the register file.
- `character_type` output 3: register-file select. 0 is Pacman, 1–4 are ghosts.
- `readwrite` output 1: 1 means write `x_in`/`y_in` to `character_type`.
- `x_in`, `y_in` output 8 each: write data.
- `query_req` output 1: maze query valid.
- `query_x`, `query_y` output 8 each: candidate coordinate being queried.
- `query_done` input 1: maze response valid.
- `query_blocked` input 1: the candidate is a wall. Qualified by `query_done`.
- `busy` output 1: a round is in progress.
- `done` output 1: one-cycle pulse when a round completes.
- `tick_overrun` output 1: one-cycle pulse when a tick is dropped.

## Operation
- States: IDLE, PAC_RD, PAC_CAP, G_RD, G_CAP, Q_PRI, Q_ALT, WRITE, NEXT, DONE.
- IDLE → PAC_RD on `tick` or pending tick. `ghost_enable` is latched on this transition.
- PAC_RD drives `character_type`=0, `readwrite`=0.
- PAC_CAP latches `regs_x_out`/`regs_y_out` as `pac_x`/`pac_y`. It then moves to G_RD with the first enabled ghost, or to DONE if the mask is 0.
- G_RD drives ghost index `g`, `readwrite`=0. G_CAP latches `gx`/`gy`.
- Axis selection, using `dx`=`pac_x`-`gx` and `dy`=`pac_y`-`gy` as 9-bit signed values:
  - The primary axis is the one with the larger |d|. Ties go to x.
  - The alternate axis is the other one, used only if its d≠0.
  - If both are 0, go G_CAP → NEXT with no query and no write.
- Candidate: the coordinate moved `STEP` toward Pacman on the axis, clamped to [0, `X_MAX`] or [0, `Y_MAX`].
  - Compute in 9 bits. Underflow saturates to 0; overflow saturates to the max.
  - If the clamped value equals the current value, the axis is treated as blocked without querying.
- Q_PRI and Q_ALT run the query handshake (rules under Timing):
  - Not blocked → WRITE with the candidate.
  - Primary blocked → Q_ALT, or NEXT if there is no alternate.
  - Alternate blocked → NEXT.
- WRITE holds `readwrite`=1, `character_type`=`g`, `x_in`/`y_in`=accepted position for exactly one cycle.
- NEXT advances `g` to the next enabled ghost in ascending order, or goes to DONE after ghost 4.
- DONE pulses `done` and returns to IDLE.
- Tick handling:
  - A `tick` while `busy` sets a one-deep pending flag.
  - A `tick` while pending is already set pulses `tick_overrun` and is dropped.
  - Pending is cleared when the next round starts, which is the cycle after DONE.

## Timing
- Reset values:
  - State IDLE.
  - `character_type`=0, `readwrite`=0, `x_in`=`y_in`=0.
  - `query_req`=0, `query_x`=`query_y`=0.
  - `busy`=`done`=`tick_overrun`=0.
  - Pending, latched mask, `g`, and coordinates all 0.
- `readwrite` is 0 in every state except WRITE, so the register file never writes spuriously.
- Register-file read latency: the select is driven in cycle N and data is sampled at the end of cycle N+1.
- Query handshake:
  - `query_req` is high from entry to Q_PRI or Q_ALT until `query_done` is sampled high. It drops the following cycle.
  - `query_x`/`query_y` are stable while `query_req` is high.
  - `query_done` may assert in the first `req` cycle.
  - `query_done` is ignored while `query_req` is low.
  - There is no timeout.
- Latency with a zero-wait responder, all ghosts enabled, and no blocks:
  - `tick` is sampled in cycle 0.
  - `busy` is high in cycles 1–19.
  - `done` pulses in cycle 19.
  - Each ghost takes 4 cycles: RD, CAP, Q, WRITE.
- `reset` mid-round:
  - Returns to IDLE the next cycle with the reset values above.
  - Any pending tick is discarded.
  - A write in progress is abandoned, and `readwrite` is 0 after the edge.
- A `tick` coinciding with DONE is latched as pending and starts the next round immediately.

## Structure
- Shared package or include holds:
  - character-type constants PACMAN=0 and GHOST1..GHOST4=1..4,
  - the state encoding,
  - the default `X_MAX`/`Y_MAX`.
- One combinational sub-module, `ghost_step_calc`:
  - Inputs: pac/ghost coordinates, `STEP`, limits.
  - Outputs: primary and alternate candidates with valid flags.
- The FSM, pending-tick logic and handshake stay in the top module.

## Test plan
- Reset, then Pacman (40,35) and ghost1 (45,35), mask 4'b0001, zero-wait non-blocking responder, one tick:
  - query (44,35),
  - single write type=1 of (44,35),
  - `done` exactly 7 cycles after tick.
- Ghost2 (45,30), Pacman (40,35), primary query blocked:
  - Q_PRI query (44,30) is answered blocked, so tie-break sends x first.
  - Q_ALT query (45,31) is accepted.
  - Write (45,31).
- Ghost at Pacman's exact position: no query and no write for that ghost. Ghost at (0,y) with Pacman further left is impossible, so check a clamp case instead:
  - `STEP`=4, ghost x=2, Pacman x=0.
  - Candidate x must be 0, not wrap to 254.
- Ticks arriving while `busy`:
  - Two ticks during one round give one pending start plus one `tick_overrun` pulse.
  - Exactly two `done` pulses in total.
- Reset asserted while waiting in Q_PRI with `query_req` high:
  - Next cycle is IDLE with `query_req`=0 and `readwrite`=0.
  - No write occurs.
  - The following tick runs a clean round.
- Responder with 3-cycle `query_done` delay:
  - `query_x`/`query_y` are held stable throughout.
  - `readwrite` is never high outside a single WRITE cycle per ghost.
